// File: rtl/xnor_line_decoder_pkg.sv
// xnor_line_pkg: shared state encoding and the XNOR line-recovery function
// for the XNOR serial line decoder and its loopback checker.
package xnor_line_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Transmitter sends line = ~(d ^ prev); invert that relation.
  function automatic logic xnor_bit(
    input logic line,
    input logic prev
  );
    return ~(line ^ prev);
  endfunction

endpackage

// File: rtl/xnor_line_decoder_if.sv
// Word-side handshake bundle of the XNOR line decoder.
// parity_err exists only when PARITY_CHECK_EN is defined.
interface xnor_line_decoder_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overrun;
`ifdef PARITY_CHECK_EN
  logic              parity_err;
`endif

  modport master (
`ifdef PARITY_CHECK_EN
    output parity_err,
`endif
    output data_out,
    output out_valid,
    output frame_err,
    output overrun,
    input  out_ready
  );

  modport slave (
`ifdef PARITY_CHECK_EN
    input  parity_err,
`endif
    input  data_out,
    input  out_valid,
    input  frame_err,
    input  overrun,
    output out_ready
  );
endinterface

// File: rtl/xnor_line_decoder_bit_recover.sv
// xnor_bit_recover: holds the previous line level and turns each strobed
// line sample into a decoded bit (shared with the encoder loopback checker).
module xnor_bit_recover
  import xnor_line_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  input  logic line_stb,
  output logic bit_val,
  output logic bit_stb
);

  logic prev_line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_line <= IDLE_LEVEL;
    end else if (line_stb) begin
      prev_line <= line_in;
    end
  end

  assign bit_val = xnor_bit(line_in, prev_line);
  assign bit_stb = line_stb;

endmodule

// File: rtl/xnor_line_decoder.sv
// xnor_line_decoder: frames XNOR-decoded bits into start/data/stop words.
// Define PARITY_CHECK_EN to add an even-parity bit between data and stop.
module xnor_line_decoder
  import xnor_line_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  input  logic line_stb,
  xnor_line_decoder_if.master out_if
);

  localparam int CNT_W =
    (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DATA_W - 1);

  logic bit_val;
  logic bit_stb;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_q;
  logic              valid_nxt;
  logic              ferr_q;
  logic              ferr_nxt;
  logic              ovr_q;
  logic              ovr_nxt;
  logic              word_done;
`ifdef PARITY_CHECK_EN
  logic              perr_q;
  logic              perr_nxt;
`endif

  xnor_bit_recover #(
    .IDLE_LEVEL(IDLE_LEVEL)
  ) u_recover (
    .clk     (clk),
    .reset   (reset),
    .line_in (line_in),
    .line_stb(line_stb),
    .bit_val (bit_val),
    .bit_stb (bit_stb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = data_q;
    valid_nxt = valid_q;
    ferr_nxt  = 1'b0;
    ovr_nxt   = 1'b0;
    word_done = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_nxt  = 1'b0;
`endif

    if (valid_q && out_if.out_ready) begin
      valid_nxt = 1'b0;
    end

    if (bit_stb) begin
      unique case (state)
        ST_IDLE: begin
          if (!bit_val) begin
            state_nxt = ST_DATA;
            cnt_nxt   = '0;
          end
        end
        ST_DATA: begin
          shift_nxt[bit_cnt] = bit_val;
          if (bit_cnt == LAST) begin
`ifdef PARITY_CHECK_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            cnt_nxt = bit_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
`ifdef PARITY_CHECK_EN
          // Even parity across data plus parity bit.
          if (bit_val == ^shift) begin
            state_nxt = ST_STOP;
          end else begin
            perr_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
`else
          state_nxt = ST_IDLE;
`endif
        end
        ST_STOP: begin
          // A bad stop bit is never reused as a start bit.
          state_nxt = ST_IDLE;
          if (bit_val) begin
            word_done = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    if (word_done) begin
      if (!valid_q || out_if.out_ready) begin
        data_nxt  = shift;
        valid_nxt = 1'b1;
      end else begin
        ovr_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      bit_cnt <= cnt_nxt;
      shift   <= shift_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
      ovr_q   <= ovr_nxt;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_nxt;
`endif
    end
  end

  assign out_if.data_out   = data_q;
  assign out_if.out_valid  = valid_q;
  assign out_if.frame_err  = ferr_q;
  assign out_if.overrun    = ovr_q;
`ifdef PARITY_CHECK_EN
  assign out_if.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_xnor_line_decoder.sv
// Scoreboard bench for xnor_line_decoder: frame-level encoder model,
// per-cycle flag queue and word queue checked by independent monitors.
module tb_xnor_line_decoder;

  localparam int DATA_W  = 8;
  localparam int EV_NONE = 0;
  localparam int EV_WORD = 1;
  localparam int EV_FERR = 2;
  localparam int EV_PERR = 3;

  typedef struct packed {
    logic valid;
    logic ferr;
    logic ovr;
    logic perr;
  } flags_t;

  logic clk = 1'b0;
  logic reset;
  logic line_in;
  logic line_stb;

  xnor_line_decoder_if #(.DATA_W(DATA_W)) bus ();

  xnor_line_decoder #(
    .DATA_W    (DATA_W),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .line_in (line_in),
    .line_stb(line_stb),
    .out_if  (bus.master)
  );

  always #5 clk = ~clk;

  flags_t            exp_q[$];
  logic [DATA_W-1:0] word_q[$];
  int                checks = 0;
  int                errors = 0;
  logic              mdl_valid;
  logic              tx_prev;
  int                rdy_mode;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Flag monitor: one expectation per driven cycle, sampled after the edge.
  always @(posedge clk) begin
    flags_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_valid", 32'(bus.out_valid), 32'(e.valid));
      check("frame_err", 32'(bus.frame_err), 32'(e.ferr));
      check("overrun", 32'(bus.overrun), 32'(e.ovr));
`ifdef PARITY_CHECK_EN
      check("parity_err", 32'(bus.parity_err), 32'(e.perr));
`endif
      if (e.valid && word_q.size() > 0) begin
        check("data_hold", 32'(bus.data_out), 32'(word_q[0]));
      end
    end
  end

  // Word monitor: pops on every accepted handshake.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (word_q.size() == 0) begin
        check("spurious_word", 32'(bus.data_out), 32'hDEAD_BEEF);
      end else begin
        check("data_out", 32'(bus.data_out),
              32'(word_q.pop_front()));
      end
    end
  end

  function automatic logic pick_rdy();
    case (rdy_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock of stimulus plus the model's expected outcome of that clock.
  task automatic tick(
    input logic              stb,
    input logic              ln,
    input logic              rdy,
    input int                ev,
    input logic [DATA_W-1:0] w
  );
    flags_t e;
    logic   acc;
    @(posedge clk);
    #2;
    line_stb      = stb;
    line_in       = ln;
    bus.out_ready = rdy;
    e   = '0;
    acc = 1'b0;
    if (ev == EV_WORD) begin
      if (!mdl_valid || rdy) begin
        acc = 1'b1;
        word_q.push_back(w);
      end else begin
        e.ovr = 1'b1;
      end
    end
    if (acc) mdl_valid = 1'b1;
    else if (mdl_valid && rdy) mdl_valid = 1'b0;
    e.valid = mdl_valid;
    e.ferr  = (ev == EV_FERR);
    e.perr  = (ev == EV_PERR);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), pick_rdy(),
           EV_NONE, '0);
    end
  endtask

  task automatic send_bit(
    input logic              b,
    input int                ev,
    input logic [DATA_W-1:0] w
  );
    logic ln;
    idle_cycles($urandom_range(0, 2));
    ln      = ~(b ^ tx_prev);
    tx_prev = ln;
    tick(1'b1, ln, pick_rdy(), ev, w);
  endtask

  task automatic send_frame(
    input logic [DATA_W-1:0] w,
    input logic              bad_stop,
    input logic              bad_par
  );
    send_bit(1'b0, EV_NONE, '0);
    for (int i = 0; i < DATA_W; i++) begin
      send_bit(w[i], EV_NONE, '0);
    end
`ifdef PARITY_CHECK_EN
    send_bit((^w) ^ bad_par, bad_par ? EV_PERR : EV_NONE, w);
    if (bad_par) return;
`endif
    send_bit(~bad_stop, bad_stop ? EV_FERR : EV_WORD, w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] w;
    int                r;
    reset         = 1'b1;
    line_stb      = 1'b0;
    line_in       = 1'b1;
    bus.out_ready = 1'b0;
    mdl_valid     = 1'b0;
    tx_prev       = 1'b1;
    rdy_mode      = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data", 32'(bus.data_out), 0);
    check("rst_ferr", 32'(bus.frame_err), 0);
    check("rst_ovr", 32'(bus.overrun), 0);
    @(negedge clk);
    reset = 1'b0;

    // 0xA5 held, then consumed
    send_frame(8'hA5, 1'b0, 1'b0);
    idle_cycles(3);
    rdy_mode = 1;
    idle_cycles(2);

    // back-to-back with ready held
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_cycles(2);

    // bad stop, then a good frame
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0);
    idle_cycles(2);

    // overrun: second word dropped while first waits
    rdy_mode = 0;
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    idle_cycles(2);
    rdy_mode = 1;
    idle_cycles(2);

`ifdef PARITY_CHECK_EN
    send_frame(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b0, 1'b1);
    idle_cycles(2);
`endif

    // reset mid-frame with a pending word
    rdy_mode = 0;
    send_frame(8'h5A, 1'b0, 1'b0);
    send_bit(1'b0, EV_NONE, '0);
    for (int i = 0; i < 4; i++) send_bit(1'(i), EV_NONE, '0);
    @(posedge clk);
    #3;
    reset         = 1'b1;
    line_stb      = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("async_valid", 32'(bus.out_valid), 0);
    check("async_data", 32'(bus.data_out), 0);
    check("async_ferr", 32'(bus.frame_err), 0);
    check("async_ovr", 32'(bus.overrun), 0);
    exp_q.delete();
    word_q.delete();
    mdl_valid = 1'b0;
    tx_prev   = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    rdy_mode = 2;
    send_frame(8'hA5, 1'b0, 1'b0);
    idle_cycles(2);

    // randomized frames, strobed idle bits and ready patterns
    for (int n = 0; n < 150; n++) begin
      w        = DATA_W'($urandom);
      r        = $urandom_range(0, 9);
      rdy_mode = $urandom_range(0, 2);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        send_bit(1'b1, EV_NONE, '0);
      end
      send_frame(w, r == 0, r == 1);
    end

    rdy_mode = 1;
    idle_cycles(4);
    repeat (2) @(posedge clk);
    #3;
    check("drain_words", 32'(word_q.size()), 0);
    check("drain_valid", 32'(bus.out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
